// File: rtl/debug_trace_buffer_pkg.sv
// Shared types for the commit-trace buffer: the queued record layout and
// the rule deciding which write-back commits are worth tracing.
package debug_trace_params;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  strobe;
        logic [4:0]  address;
        logic [31:0] data;
    } TraceRecord;

    localparam int RECORD_W = $bits(TraceRecord);

    // A commit is traced only if it writes something, optionally ignoring x0.
    function automatic logic push_qualifies(input logic [3:0] strobe,
                                            input logic [4:0] address,
                                            input logic       drop_zero);
        return (strobe != 4'd0) && !(drop_zero && (address == 5'd0));
    endfunction

endpackage

// File: rtl/debug_trace_buffer_if.sv
// Drain-side valid/ready port of the trace buffer; master is the buffer,
// slave is the comparator or trace link consuming records.
interface debug_trace_buffer_if;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_program_count;
    logic [3:0]  trace_write_strobe;
    logic [4:0]  trace_write_address;
    logic [31:0] trace_write_data;

    modport master (
        output trace_valid, trace_program_count, trace_write_strobe,
               trace_write_address, trace_write_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_program_count, trace_write_strobe,
               trace_write_address, trace_write_data,
        output trace_ready
    );
endinterface

// File: rtl/debug_trace_buffer_fifo.sv
// Generic show-ahead FIFO: head is read combinationally at the read pointer,
// pointers carry one extra wrap bit to tell full from empty.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/debug_trace_buffer.sv
// Captures qualifying write-back commits every cycle into a show-ahead FIFO
// and drains them over valid/ready; records that find the FIFO full are counted.
module debug_trace_buffer
    import debug_trace_params::*;
#(
    parameter int DEPTH         = 16,
    parameter bit DROP_ZERO_REG = 1'b1,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              debug_program_count,
    input  logic [3:0]               debug_register_file_write_enabled,
    input  logic [4:0]               debug_register_file_write_address,
    input  logic [31:0]              debug_register_file_write_data,
    input  logic                     clear,
    debug_trace_buffer_if.master     trace,
    output logic [$clog2(DEPTH):0]   trace_level,
    output logic                     trace_overflow,
    output logic [COUNT_WIDTH-1:0]   trace_dropped_count
);
    TraceRecord in_rec, head;
    logic       push_req, pop, drop, full, empty;

    assign in_rec = '{pc:      debug_program_count,
                      strobe:  debug_register_file_write_enabled,
                      address: debug_register_file_write_address,
                      data:    debug_register_file_write_data};

    assign push_req = push_qualifies(debug_register_file_write_enabled,
                                     debug_register_file_write_address,
                                     DROP_ZERO_REG);
    assign pop  = trace.trace_valid && trace.trace_ready;
    // The core cannot stall, so a record arriving at a full, non-draining FIFO is lost.
    assign drop = push_req && full && !pop;

    trace_fifo #(.WIDTH(RECORD_W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push_req),
        .pop   (pop),
        .wdata (in_rec),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (trace_level)
    );

    assign trace.trace_valid         = !empty;
    assign trace.trace_program_count = head.pc;
    assign trace.trace_write_strobe  = head.strobe;
    assign trace.trace_write_address = head.address;
    assign trace.trace_write_data    = head.data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trace_overflow      <= 1'b0;
            trace_dropped_count <= '0;
        end else if (clear) begin
            trace_overflow      <= 1'b0;
            trace_dropped_count <= '0;
        end else if (drop) begin
            trace_overflow <= 1'b1;
            if (trace_dropped_count != '1)
                trace_dropped_count <= trace_dropped_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Sits directly downstream of cpu_core's trace debug interface.
- Each cycle it samples the write-back commit record (pc, register-file write strobe, register address, write data), filters it and queues it in a FIFO.
- Drains the FIFO over a valid/ready port to the testbench golden-trace comparator or an off-chip trace link.
- Decouples bursty write-back commits from a slower consumer and flags any record loss.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DROP_ZERO_REG, 1, when 1 discard records whose address is 0.
- COUNT_WIDTH, 16, width of the saturating dropped-record counter.

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- debug_program_count  input  32  commit pc from write-back
- debug_register_file_write_enabled  input  4  byte write strobe; 0 = no write
- debug_register_file_write_address  input  5  destination register
- debug_register_file_write_data  input  32  written data
- clear  input  1  synchronous flush of FIFO, overflow flag and drop counter
- trace_valid  output  1  head record available
- trace_ready  input  1  consumer accepts head record
- trace_program_count  output  32  head pc
- trace_write_strobe  output  4  head strobe
- trace_write_address  output  5  head register
- trace_write_data  output  32  head data
- trace_level  output  $clog2(DEPTH)+1  occupied entries
- trace_overflow  output  1  sticky; set when a record was dropped
- trace_dropped_count  output  COUNT_WIDTH  saturating count of dropped records

Behaviour:
- Reset:
  - Asynchronous assert clears read pointer, write pointer, trace_level, trace_overflow and trace_dropped_count.
  - trace_valid = 0 during and after reset.
  - Data outputs are don't-care while trace_valid = 0; the RAM array is not reset.
- Record qualification:
  - push_req = (strobe != 0) && !(DROP_ZERO_REG && address == 0).
  - Sampled every rising edge; no input handshake, because the core cannot stall on trace.
- Pop:
  - pop = trace_valid && trace_ready.
  - The head is driven combinationally from the RAM at the read pointer (zero-latency show-ahead).
- Push acceptance:
  - Push is accepted when level < DEPTH, or when level == DEPTH and pop occurs in the same cycle.
  - Full with simultaneous pop accepts the new record; level stays at DEPTH.
  - Empty with push_req: the record becomes visible with trace_valid = 1 on the next cycle (1-cycle latency). There is no bypass, so empty plus push never pops in the same cycle.
- Drop:
  - push_req while full and no pop sets trace_overflow = 1 and increments trace_dropped_count.
  - The counter saturates at all-ones and does not wrap.
  - The incoming record is discarded; queued records are untouched (oldest-kept policy).
- Pointers:
  - $clog2(DEPTH)+1 bits each; wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - trace_level = wr - rd.
- clear:
  - Synchronous; on the next edge pointers are equalised, the flag is cleared and the counter is zeroed.
  - clear has priority over push and pop in the same cycle; both are ignored that cycle.
- Reset mid-stream: all queued records are lost; no partial record remains visible.
- The output payload stays stable while trace_valid && !trace_ready.

Decomposition:
- Add debug_trace_params package:
  - TraceRecord packed struct {pc 32, strobe 4, address 5, data 32} (73 bits).
  - A helper function for push qualification.
- Natural sub-module: trace_fifo, a generic synchronous show-ahead FIFO parameterised on width and depth, exposing push/pop/full/empty/level.
- debug_trace_buffer adds the qualification, drop accounting and clear on top of trace_fifo.

Test Plan:
- Reset then idle inputs (strobe = 0) for 10 cycles -> trace_valid = 0, trace_level = 0, trace_overflow = 0.
- Single commit {pc 0xBFC00000, strobe 0xF, addr 8, data 0x1234} with trace_ready = 1 -> next cycle trace_valid = 1 with the same fields; popped that cycle; level returns to 0.
- trace_ready = 0, 20 back-to-back qualifying commits, DEPTH = 16 -> level = 16, overflow = 1, dropped_count = 4; draining yields the first 16 pcs in order.
- Full FIFO, trace_ready = 1 plus a qualifying commit every cycle for 8 cycles -> level stays 16, dropped_count unchanged, output order intact.
- Commit to addr 0 with strobe 0xF, DROP_ZERO_REG = 1 -> not queued; with DROP_ZERO_REG = 0 -> queued.
- Asynchronous reset asserted mid-cycle with 5 entries queued -> trace_valid drops immediately; after release level = 0 and counters are zero. Separately, clear together with a push -> level = 0 next cycle.
